div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one restoring divider (8-bit M/Q, start/busy handshake, serial outbus: quotient then remainder) between N_REQ requesters.
- Arbitrates round-robin and latches the granted operands.
- Resets and launches the divider, captures the two serial output words and returns quotient/remainder with a done pulse.
- Sits between requesting datapaths and the single divider instance.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 8, operand/result width; must match the divider.
- TIMEOUT, 31, max cycles in RUN before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- req_m  in  N_REQ*WIDTH  divisors, requester i at bits [i*WIDTH +: WIDTH].
- req_q  in  N_REQ*WIDTH  dividends, same packing.
- gnt  out  N_REQ  one-hot grant.
- done  out  N_REQ  one-cycle completion pulse, one-hot.
- quot  out  WIDTH  quotient of the last completed op.
- rem  out  WIDTH  remainder of the last completed op.
- err  out  1  valid with done; 1 = timeout abort.
- div_m  out  WIDTH  divider M.
- div_q  out  WIDTH  divider Q.
- div_start  out  1  divider start.
- div_reset  out  1  divider reset, active-high.
- div_busy  in  1  divider busy.
- div_outbus  in  WIDTH  divider output bus.

Behaviour:
- Reset (reset=0): state IDLE; gnt, done, quot, rem, err, div_m, div_q, div_start = 0; rr pointer points at requester 0, so it wins first. div_reset = 1 combinationally while reset=0.
- IDLE: if any req bit is set, go to ARB.
- ARB: pick the first set req scanning upward from (last_served+1) mod N_REQ. Assert gnt for it. Latch div_m/div_q from its slice. Update last_served. Go to CLR.
- CLR: div_reset=1 for exactly one cycle; the divider halts in DONE and must be cleared before each operation. Go to LAUNCH.
- LAUNCH: div_start=1. Hold it until div_busy=1 is sampled, then deassert and go to RUN.
- RUN: each cycle register div_outbus into prev_out and increment the watchdog.
  - On div_busy=0: quot<=prev_out, rem<=div_outbus, err<=0, go to RESP.
  - If the watchdog reaches TIMEOUT first: quot=rem=0, err<=1, go to RESP.
- RESP: done[granted]=1 for one cycle. On a timeout, div_reset is also asserted this cycle. Next state IDLE; gnt drops on that transition.
- gnt is held from ARB through RESP. quot/rem/err are held until the next RESP.
- Requesters keep req high until their done pulse. If req drops mid-operation, the operation still completes and done still pulses.
- After a grant, a new arbitration needs at least IDLE→ARB, so there are no back-to-back grants in consecutive cycles.
- A requester holding req after its done is rescheduled only after the other pending requesters (fairness).
- div_start and div_reset are never high in the same cycle.
- Latency: with a divider busy width of 11 cycles, done asserts 16 cycles after req rises in IDLE.

Decomposition:
- Shared package/include (alongside the existing FSM state defines): state encodings DA_IDLE, DA_ARB, DA_CLR, DA_LAUNCH, DA_RUN, DA_RESP.
- One sub-module, rr_picker: combinational round-robin priority pick from req and last_served, returning a one-hot grant and its index.
- FSM and capture logic stay in div_arbiter.

Test Plan:
- Single op: reset, req[0]=1, M=3, Q=20, protocol-accurate divider model → div_reset pulse, then start; done[0] at +16 cycles with quot=6, rem=2, err=0.
- Contention: req=2'b11 with (M=5,Q=17) and (M=4,Q=9) → first done[0] with 3/2, then done[1] with 2/1; gnt never two-hot.
- Fairness: req[0] held permanently, req[1] rises during op 0 → next grant goes to requester 1 before requester 0 is served again.
- Timeout: model holds busy=1 forever → done pulse with err=1, quot=rem=0, div_reset high in RESP; next request completes normally.
- Reset mid-RUN: reset=0 at cycle 8 → all outputs 0, div_reset=1, no done; after release, req[1] is served correctly.
- Request withdrawn: req[0] dropped during RUN → done[0] still pulses once; the FSM returns to IDLE and stays there.

Source files
------------

// File: rtl/div_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM state encoding and a small
// wrap-around helper used by the round-robin picker.
package div_arbiter_pkg;

    typedef enum logic [2:0] {
        DA_IDLE   = 3'd0,
        DA_ARB    = 3'd1,
        DA_CLR    = 3'd2,
        DA_LAUNCH = 3'd3,
        DA_RUN    = 3'd4,
        DA_RESP   = 3'd5
    } da_state_t;

    // Single-step modulo for values known to be below 2*n.
    function automatic int da_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Link between the arbiter and the single restoring divider.
// Handshake: the master raises div_start and holds it until the divider
// reports div_busy=1; while busy the divider streams on div_outbus, showing
// the quotient in its last busy cycle and the remainder once busy drops.
// div_reset (active-high) returns the divider from its halted DONE state.
interface div_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] div_m;
    logic [WIDTH-1:0] div_q;
    logic             div_start;
    logic             div_reset;
    logic             div_busy;
    logic [WIDTH-1:0] div_outbus;

    modport master (
        output div_m, div_q, div_start, div_reset,
        input  div_busy, div_outbus
    );

    modport slave (
        input  div_m, div_q, div_start, div_reset,
        output div_busy, div_outbus
    );
endinterface

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request scanning upward from
// the requester after last_served, wrapping around.
module rr_picker
    import div_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_served,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Scan N_REQ positions starting one past the last served requester.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'(da_wrap(int'(last_served) + i, N_REQ));
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one restoring divider between N_REQ requesters: round-robin grant,
// clear + launch of the divider, capture of the serial quotient/remainder,
// a watchdog abort, and a one-hot done pulse back to the winner.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_m,
    input  logic [N_REQ*WIDTH-1:0] req_q,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       quot,
    output logic [WIDTH-1:0]       rem,
    output logic                   err,
    div_arbiter_if.master          dbus,
    output da_state_t              dbg_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    da_state_t        state;
    da_state_t        state_nxt;
    logic [IDX_W-1:0] last_served;
    logic [WIDTH-1:0] prev_out;
    logic [WD_W-1:0]  wd;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] q_r;
    logic             start_c;
    logic             dreset_c;
    logic             timeout_hit;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req         (req),
        .last_served (last_served),
        .gnt         (pick_gnt),
        .idx         (pick_idx),
        .valid       (pick_valid)
    );

    // The cycle that would bring the watchdog count up to TIMEOUT.
    assign timeout_hit = (wd == WD_W'(TIMEOUT - 1));

    assign dbus.div_m     = m_r;
    assign dbus.div_q     = q_r;
    assign dbus.div_start = start_c;
    assign dbus.div_reset = dreset_c;
    assign dbg_state      = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= DA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a busy drop wins over a same-cycle watchdog expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            DA_IDLE:   if (|req) state_nxt = DA_ARB;
            DA_ARB:    state_nxt = pick_valid ? DA_CLR : DA_IDLE;
            DA_CLR:    state_nxt = DA_LAUNCH;
            DA_LAUNCH: if (dbus.div_busy) state_nxt = DA_RUN;
            DA_RUN:    if (!dbus.div_busy || timeout_hit) state_nxt = DA_RESP;
            DA_RESP:   state_nxt = DA_IDLE;
            default:   state_nxt = DA_IDLE;
        endcase
    end

    // Decoded outputs: divider clear/start strobes and the done pulse.
    always_comb begin
        start_c  = 1'b0;
        dreset_c = !reset;
        done     = '0;
        case (state)
            DA_CLR:    dreset_c = 1'b1;
            DA_LAUNCH: start_c  = 1'b1;
            DA_RESP: begin
                done = gnt;
                // A timed-out divider is still busy and must be cleared.
                if (err) dreset_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Grant/operand latching, watchdog and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt         <= '0;
            last_served <= IDX_W'(N_REQ - 1);
            m_r         <= '0;
            q_r         <= '0;
            prev_out    <= '0;
            wd          <= '0;
            quot        <= '0;
            rem         <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                DA_ARB: begin
                    if (pick_valid) begin
                        gnt         <= pick_gnt;
                        last_served <= pick_idx;
                        m_r         <= req_m[int'(pick_idx)*WIDTH +: WIDTH];
                        q_r         <= req_q[int'(pick_idx)*WIDTH +: WIDTH];
                    end
                end
                DA_LAUNCH: wd <= '0;
                DA_RUN: begin
                    prev_out <= dbus.div_outbus;
                    wd       <= wd + WD_W'(1);
                    if (!dbus.div_busy) begin
                        // Quotient was on the bus last cycle, remainder is on it now.
                        quot <= prev_out;
                        rem  <= dbus.div_outbus;
                        err  <= 1'b0;
                    end else if (timeout_hit) begin
                        quot <= '0;
                        rem  <= '0;
                        err  <= 1'b1;
                    end
                end
                DA_RESP: gnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: protocol-level divider model, round-robin reference
// model with an expected-result queue, directed scenarios and random traffic.
module tb_div_arbiter;
    import div_arbiter_pkg::*;

    localparam int N_REQ    = 2;
    localparam int WIDTH    = 8;
    localparam int TIMEOUT  = 31;
    localparam int BUSY_LEN = 11;
    localparam int EW       = 4 + WIDTH + WIDTH + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] req_m = '0;
    logic [N_REQ*WIDTH-1:0] req_q = '0;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       quot;
    logic [WIDTH-1:0]       rem;
    logic                   err;
    da_state_t              dbg_state;

    div_arbiter_if #(.WIDTH(WIDTH)) dbus();

    div_arbiter #(
        .N_REQ   (N_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_m     (req_m),
        .req_q     (req_q),
        .gnt       (gnt),
        .done      (done),
        .quot      (quot),
        .rem       (rem),
        .err       (err),
        .dbus      (dbus),
        .dbg_state (dbg_state)
    );

    // ---------------- check / counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // ---------------- divider model ----------------
    // 0 idle, 1 busy, 2 halted in DONE (ignores start until div_reset)
    logic             hang_mode = 1'b0;
    int               dv_state = 0;
    int               dv_cnt = 0;
    logic             dv_busy = 1'b0;
    logic [WIDTH-1:0] dv_out = '0;
    logic [WIDTH-1:0] dv_quot = '0;
    logic [WIDTH-1:0] dv_rem = '0;

    assign dbus.div_busy   = dv_busy;
    assign dbus.div_outbus = dv_out;

    always @(posedge clk) begin
        if (dbus.div_reset) begin
            dv_state <= 0;
            dv_busy  <= 1'b0;
            dv_cnt   <= 0;
        end else begin
            case (dv_state)
                0: if (dbus.div_start) begin
                    dv_quot  <= dbus.div_q / dbus.div_m;
                    dv_rem   <= dbus.div_q % dbus.div_m;
                    dv_busy  <= 1'b1;
                    dv_cnt   <= BUSY_LEN;
                    dv_state <= 1;
                    dv_out   <= WIDTH'($urandom);
                end
                1: begin
                    if (hang_mode) begin
                        dv_out <= WIDTH'($urandom);
                    end else begin
                        dv_cnt <= dv_cnt - 1;
                        if (dv_cnt == 2) dv_out <= dv_quot;
                        else if (dv_cnt == 1) begin
                            dv_busy  <= 1'b0;
                            dv_out   <= dv_rem;
                            dv_state <= 2;
                        end else dv_out <= WIDTH'($urandom);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    done_log[$];
    int               done_order[$];
    int               model_last = N_REQ - 1;
    logic [N_REQ-1:0] req_at_edge = '0;
    logic [N_REQ-1:0] prev_gnt = '0;

    always @(posedge clk) req_at_edge <= req;

    function automatic int rr_expected(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    always begin
        logic [EW-1:0]    e;
        logic [WIDTH-1:0] mv;
        logic [WIDTH-1:0] qv;
        int               w;
        int               di;
        @(posedge clk);
        #1;
        if (!reset) begin
            prev_gnt = '0;
        end else begin
            check("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
            check("start_reset_excl", 32'(dbus.div_start & dbus.div_reset), 32'd0);
            if (gnt != '0 && prev_gnt == '0) begin
                w = rr_expected(req_at_edge, model_last);
                check("grant", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
                if (w >= 0) begin
                    model_last = w;
                    mv = req_m[w*WIDTH +: WIDTH];
                    qv = req_q[w*WIDTH +: WIDTH];
                    if (hang_mode) exp_q.push_back({4'(w), {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b1});
                    else exp_q.push_back({4'(w), WIDTH'(qv / mv), WIDTH'(qv % mv), 1'b0});
                end
            end
            prev_gnt = gnt;
            if (done != '0) begin
                di = 0;
                for (int i = 0; i < N_REQ; i++) if (done[i]) di = i;
                done_order.push_back(di);
                done_log.push_back({4'(di), quot, rem, err});
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_onehot", 32'(done), 32'd1 << e[EW-1 -: 4]);
                    check("quot", 32'(quot), 32'(e[2*WIDTH:WIDTH+1]));
                    check("rem", 32'(rem), 32'(e[WIDTH:1]));
                    check("err", 32'(err), 32'(e[0]));
                    check("div_reset_in_resp", 32'(dbus.div_reset), 32'(e[0]));
                end
            end
        end
    end

    function automatic int order_at(input int k);
        if (k < 0 || k >= done_order.size()) return -1;
        return done_order[k];
    endfunction

    function automatic logic [EW-1:0] log_last();
        if (done_log.size() == 0) return '1;
        return done_log[done_log.size() - 1];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input int m, input int q);
        req_m[i*WIDTH +: WIDTH] = WIDTH'(m);
        req_q[i*WIDTH +: WIDTH] = WIDTH'(q);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_quot"}, 32'(quot), 32'd0);
        check({tag, "_rem"}, 32'(rem), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_div_m"}, 32'(dbus.div_m), 32'd0);
        check({tag, "_div_q"}, 32'(dbus.div_q), 32'd0);
        check({tag, "_div_start"}, 32'(dbus.div_start), 32'd0);
        check({tag, "_div_reset"}, 32'(dbus.div_reset), 32'd1);
        check({tag, "_state"}, 32'(dbg_state), 32'(DA_IDLE));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        exp_q.delete();
        model_last = N_REQ - 1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Wait for done on every bit of mask; drop req on done unless kept.
    task automatic wait_all(input logic [N_REQ-1:0] mask, input logic [N_REQ-1:0] keep,
                            input int budget);
        logic [N_REQ-1:0] pending;
        int cycles;
        pending = mask;
        cycles = 0;
        while (pending != '0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
            for (int i = 0; i < N_REQ; i++) begin
                if (pending[i] && done[i]) begin
                    pending[i] = 1'b0;
                    if (!keep[i]) req[i] = 1'b0;
                end
            end
        end
        check("wait_done_budget", 32'(pending), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int clr_at;
        int start_at;
        int base;
        int c0;
        int polls;
        logic [EW-1:0] lg;
        logic [N_REQ-1:0] mask;

        // reset state
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // single op with latency and clear-before-start ordering
        set_op(0, 3, 20);
        req[0] = 1'b1;
        lat = 0;
        clr_at = -1;
        start_at = -1;
        while (lat < 40 && !done[0]) begin
            @(posedge clk);
            #1;
            lat++;
            if (dbus.div_reset && clr_at < 0) clr_at = lat;
            if (dbus.div_start && start_at < 0) start_at = lat;
        end
        check("single_latency", 32'(lat), 32'd16);
        check("single_clr_cycle", 32'(clr_at), 32'd2);
        check("single_start_cycle", 32'(start_at), 32'd3);
        check("single_quot", 32'(quot), 32'd6);
        check("single_rem", 32'(rem), 32'd2);
        check("single_err", 32'(err), 32'd0);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // contention from a fresh pointer
        apply_reset();
        set_op(0, 5, 17);
        set_op(1, 4, 9);
        base = done_order.size();
        req = 2'b11;
        wait_all(2'b11, 2'b00, 200);
        check("contend_first", 32'(order_at(base)), 32'd0);
        check("contend_second", 32'(order_at(base + 1)), 32'd1);
        check("contend_log0", 32'(done_log[base]), 32'({4'd0, 8'd3, 8'd2, 1'b0}));
        check("contend_log1", 32'(log_last()), 32'({4'd1, 8'd2, 8'd1, 1'b0}));

        // fairness: req[0] held across its done, req[1] arrives mid-op
        @(negedge clk);
        set_op(0, 7, 200);
        set_op(1, 13, 99);
        base = done_order.size();
        req[0] = 1'b1;
        repeat (6) @(negedge clk);
        req[1] = 1'b1;
        wait_all(2'b01, 2'b01, 100);
        wait_all(2'b10, 2'b00, 100);
        wait_all(2'b01, 2'b00, 100);
        check("fair_0", 32'(order_at(base)), 32'd0);
        check("fair_1", 32'(order_at(base + 1)), 32'd1);
        check("fair_2", 32'(order_at(base + 2)), 32'd0);

        // timeout abort then a normal op
        @(negedge clk);
        hang_mode = 1'b1;
        set_op(0, 7, 50);
        req[0] = 1'b1;
        wait_all(2'b01, 2'b00, 100);
        check("timeout_log", 32'(log_last()), 32'({4'd0, 8'd0, 8'd0, 1'b1}));
        @(negedge clk);
        hang_mode = 1'b0;
        set_op(1, 9, 100);
        req[1] = 1'b1;
        wait_all(2'b10, 2'b00, 100);
        check("after_timeout_log", 32'(log_last()), 32'({4'd1, 8'd11, 8'd1, 1'b0}));

        // reset in the middle of RUN
        @(negedge clk);
        set_op(0, 2, 77);
        req[0] = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("midrun_state", 32'(dbg_state), 32'(DA_RUN));
        reset = 1'b0;
        req = '0;
        exp_q.delete();
        model_last = N_REQ - 1;
        #1;
        check_reset_outputs("midrun");
        repeat (3) @(negedge clk);
        check("midrun_hold_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        set_op(1, 6, 45);
        req[1] = 1'b1;
        wait_all(2'b10, 2'b00, 100);
        check("after_reset_log", 32'(log_last()), 32'({4'd1, 8'd7, 8'd3, 1'b0}));

        // request withdrawn during RUN
        @(negedge clk);
        set_op(0, 10, 255);
        req[0] = 1'b1;
        polls = 0;
        while (dbg_state != DA_RUN && polls < 30) begin
            @(negedge clk);
            polls++;
        end
        check("withdraw_reach_run", 32'(dbg_state), 32'(DA_RUN));
        req[0] = 1'b0;
        c0 = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[0]) c0++;
        end
        check("withdraw_done_once", 32'(c0), 32'd1);
        check("withdraw_idle", 32'(dbg_state), 32'(DA_IDLE));
        check("withdraw_gnt", 32'(gnt), 32'd0);
        lg = log_last();
        check("withdraw_log", 32'(lg), 32'({4'd0, 8'd25, 8'd5, 1'b0}));

        // random traffic
        for (int it = 0; it < 16; it++) begin
            @(negedge clk);
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) set_op(i, $urandom_range(1, 255), $urandom_range(0, 255));
            req = mask;
            wait_all(mask, '0, 200);
        end

        repeat (4) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global time limit reached");
    end

endmodule
